serial_byte_loader: RTL
=======================

# serial_byte_loader

- Upstream feeder for the `regN` parallel register.
- Collects a framed serial bit stream MSB-first and assembles N-bit words.
- For each completed word, presents it on `d` and pulses `load` for exactly one cycle, so `regN` captures it on the following edge.
- A partial word cut off by frame deassertion is discarded and flagged.

## Interface
- `N`, 8, word width; matches `regN` data width; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input on the same edge.
- `frame`  in  1  high while a transfer is in progress; bits are sampled only while high.
- `sin`  in  1  serial data bit, MSB first.
- `sin_valid`  in  1  `sin` is valid this cycle; sampled only when `frame` = 1.
- `d`  out  N  last completed word; drives `regN.d`.
- `load`  out  1  one-cycle pulse, word on `d` is new; drives `regN.load`.
- `busy`  out  1  partial word held (state SHIFT).
- `abort_err`  out  1  one-cycle pulse, partial word discarded.
- `bit_cnt`  out  $clog2(N)  bits captured in current word.

## Operation
- FSM states: IDLE, SHIFT.
- Internal registers: shift register `sh[N-1:0]` and counter `bit_cnt`.
- A bit is taken when `frame` = 1 and `sin_valid` = 1 on a rising edge: `sh <= {sh[N-2:0], sin}`, `bit_cnt` + 1.
- IDLE:
  - On a take, go to SHIFT with `bit_cnt` = 1.
  - Otherwise stay in IDLE. `frame` alone does nothing.
- SHIFT, take with `bit_cnt` = N-1 (word completes):
  - `d <= {sh[N-2:0], sin}` and `load <= 1`.
  - `bit_cnt <= 0`; go to IDLE.
- SHIFT, `frame` = 1 and `sin_valid` = 0: hold all state; no timeout.
- SHIFT, `frame` = 0: go to IDLE with `bit_cnt <= 0` and `abort_err <= 1`. `sh` contents are dropped; `d` and `load` are unaffected.
- `load` and `abort_err` are high for exactly one cycle per event and never high together.
- `d` changes only when a word completes; it holds its value between words and during aborts.
- Back-to-back words: a take in the cycle right after completion starts the next word from IDLE. There are no gap cycles, so sustained throughput is 1 bit per clock.
- `busy` = (state == SHIFT).
- `frame` falling in IDLE: no effect, no error.

## Timing
- Reset values: `d` = 0, `load` = 0, `busy` = 0, `abort_err` = 0, `bit_cnt` = 0, `sh` = 0, state IDLE.
- All outputs are registered; there is no combinational path from input to output.
- Latency:
  - Edge k takes the Nth bit.
  - `load` = 1 and the new `d` are visible during cycle k→k+1.
  - `regN.q` updates at edge k+1.
- Same-edge cases:
  - `frame` = 0 with `sin_valid` = 1 on what would be the Nth bit: no take; abort if in SHIFT.
  - `reset` = 1 mid-word: all state returns to reset values at that edge; no `load` and no `abort_err` are issued for the partial word.
  - `reset` = 1 on the completing edge: reset wins and `load` stays 0.
- Counter wrap: `bit_cnt` never exceeds N-1; completion forces it to 0.

## Structure
- Shared package `regn_pkg`:
  - `localparam int REG_W = 8` (default for `N` here and in `regN`).
  - `typedef enum logic {IDLE, SHIFT} sbl_state_t`.
- Single flat module with no sub-module. The bit counter and shift register are inline `always_ff` logic.
- The integration bench instantiates `serial_byte_loader` → `regN` with `d`/`load` wired directly.

## Test plan
- Reset: hold `reset` = 1 for 2 edges → all outputs 0 and `q` = 8'h00; release with `frame` = 0 → outputs stay 0.
- Single word: `frame` = 1, bits 1,0,1,0,1,0,1,0 with `sin_valid` = 1 on consecutive edges → one `load` pulse with `d` = 8'hAA after the 8th edge; `regN.q` = 8'hAA one edge later; `abort_err` never high.
- Gapped and back-to-back words: 8'hFF with `sin_valid` low for 3 cycles mid-word, then 8'h0F immediately after → two `load` pulses, 8'hFF then 8'h0F; `bit_cnt` holds during the gap.
- Abort: 5 bits taken, then `frame` = 0 → `abort_err` pulses once, no `load`, `d` keeps its previous value (8'h0F); a subsequent full word 8'h55 loads correctly.
- Mid-word reset: 4 bits in, `reset` = 1 for 1 edge → `d` = 0, `bit_cnt` = 0, `busy` = 0, no `load`/`abort_err`; a following word 8'h3C completes normally.
- Edge case: `frame` drops on the edge presenting the 8th bit → `abort_err` = 1, `load` = 0, `d` unchanged.

Source files
------------

// File: rtl/regn_pkg.sv
// Shared definitions for the regN register family and its serial feeder.
package regn_pkg;

  localparam int REG_W = 8;

  typedef enum logic {IDLE, SHIFT} sbl_state_t;

endpackage

// File: rtl/serial_byte_loader.sv
// Assembles a framed MSB-first serial stream into N-bit words and hands each
// completed word to regN with a one-cycle load pulse.
module serial_byte_loader
  import regn_pkg::*;
#(
  parameter int unsigned N = REG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 sin,
  input  logic                 sin_valid,
  output logic [N-1:0]         d,
  output logic                 load,
  output logic                 busy,
  output logic                 abort_err,
  output logic [$clog2(N)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  sbl_state_t      state_q, state_d;
  // The Nth bit goes straight into d, so only N-1 pending bits need storage.
  logic [N-2:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    d_q, d_d;
  logic            load_q, load_d;
  logic            abort_q, abort_d;
  logic            take;
  logic [N-1:0]    shifted;

  assign take    = frame & sin_valid;
  assign shifted = {sh_q, sin};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      load_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      load_q  <= load_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    load_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          sh_d    = shifted[N-2:0];
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!frame) begin
          sh_d    = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sin_valid) begin
          if (cnt_q == LastCnt) begin
            d_d     = shifted;
            load_d  = 1'b1;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sh_d  = shifted[N-2:0];
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d         = d_q;
  assign load      = load_q;
  assign abort_err = abort_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == SHIFT);

endmodule
